// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FP_ENTRY_W = 1 + REG_W + 2 * DATA_W;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_LAST = 5'd31;

  typedef struct packed {
    logic              dbl;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
  } fpEntry_t;

  typedef enum logic {
    INT_PRI  = 1'b0,
    FP_FORCE = 1'b1
  } wbState_t;

  // r0 is never writable; a double at r31 would spill past the file.
  function automatic logic fpIllegal(input logic dbl, input logic [REG_W-1:0] rg);
    return (rg == REG_ZERO) || (dbl && (rg == REG_LAST));
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering pending float writebacks (power-of-2 depth).
module rf_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 70
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rdPtr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges integer and float writebacks onto the register-file write port, one class per cycle.
// Optional RF_WB_BYPASS_EN: legal float writes skip an empty FIFO when the slot is free.
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned FP_DEPTH   = 4,
  parameter int unsigned STREAK_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       int_valid,
  output logic                       int_ready,
  input  logic [4:0]                 int_reg,
  input  logic [31:0]                int_data,
  input  logic                       fp_valid,
  output logic                       fp_ready,
  input  logic                       fp_dbl,
  input  logic [4:0]                 fp_reg,
  input  logic [31:0]                fp_data1,
  input  logic [31:0]                fp_data2,
  output logic [4:0]                 writeReg,
  output logic [31:0]                writeData,
  output logic                       regWrite,
  output logic [4:0]                 writeRegf,
  output logic [31:0]                writeData1f,
  output logic [31:0]                writeData2f,
  output logic                       regWritef,
  output logic                       regDWritef,
  output logic                       fp_err,
  output logic [$clog2(FP_DEPTH):0]  fp_count
);
  localparam int unsigned STREAK_W = $clog2(STREAK_MAX + 1);

  wbState_t            state, stateNext;
  logic [STREAK_W-1:0] streak, streakNext;

  fpEntry_t fpIn, fpHead, issueEnt;
  logic     fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic     intAcc, fpAcc, fpBad, fpBypass, issueFp;

  logic [4:0]  writeRegN, writeRegfN;
  logic [31:0] writeDataN, writeData1fN, writeData2fN;
  logic        regWriteN, regWritefN, regDWritefN, fpErrN;

  assign int_ready = (state != FP_FORCE);
  assign fp_ready  = ~fifoFull;
  assign intAcc    = int_valid & int_ready;
  assign fpAcc     = fp_valid & fp_ready;
  assign fpBad     = fpIllegal(fp_dbl, fp_reg);
  assign fpIn      = '{dbl: fp_dbl, dest: fp_reg, data1: fp_data1, data2: fp_data2};

  rf_wb_fifo #(
    .DEPTH (FP_DEPTH),
    .WIDTH (FP_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .wdata (fpIn),
    .rdata (fpHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fp_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INT_PRI;
      streak      <= '0;
      writeReg    <= '0;
      writeData   <= '0;
      regWrite    <= 1'b0;
      writeRegf   <= '0;
      writeData1f <= '0;
      writeData2f <= '0;
      regWritef   <= 1'b0;
      regDWritef  <= 1'b0;
      fp_err      <= 1'b0;
    end else begin
      state       <= stateNext;
      streak      <= streakNext;
      writeReg    <= writeRegN;
      writeData   <= writeDataN;
      regWrite    <= regWriteN;
      writeRegf   <= writeRegfN;
      writeData1f <= writeData1fN;
      writeData2f <= writeData2fN;
      regWritef   <= regWritefN;
      regDWritef  <= regDWritefN;
      fp_err      <= fpErrN;
    end
  end

  // Issue decision: strobes default low, index/data hold their last values.
  always_comb begin
    stateNext    = state;
    streakNext   = streak;
    fifoPop      = 1'b0;
    fpBypass     = 1'b0;
    issueFp      = 1'b0;
    issueEnt     = fpHead;
    writeRegN    = writeReg;
    writeDataN   = writeData;
    regWriteN    = 1'b0;
    writeRegfN   = writeRegf;
    writeData1fN = writeData1f;
    writeData2fN = writeData2f;
    regWritefN   = 1'b0;
    regDWritefN  = 1'b0;
    fpErrN       = fpAcc & fpBad;

    case (state)
      INT_PRI: begin
        if (intAcc) begin
          writeRegN  = int_reg;
          writeDataN = int_data;
          regWriteN  = (int_reg != REG_ZERO);
          if (fifoEmpty) begin
            streakNext = '0;
          end else if (streak == STREAK_W'(STREAK_MAX - 1)) begin
            streakNext = STREAK_W'(STREAK_MAX);
            stateNext  = FP_FORCE;
          end else begin
            streakNext = streak + STREAK_W'(1);
          end
        end else if (!fifoEmpty) begin
          issueFp    = 1'b1;
          fifoPop    = 1'b1;
          streakNext = '0;
        end else begin
          streakNext = '0;
`ifdef RF_WB_BYPASS_EN
          if (fpAcc && !fpBad) begin
            issueFp  = 1'b1;
            issueEnt = fpIn;
            fpBypass = 1'b1;
          end
`endif
        end
      end
      FP_FORCE: begin
        issueFp    = ~fifoEmpty;
        fifoPop    = ~fifoEmpty;
        streakNext = '0;
        stateNext  = INT_PRI;
      end
      default: begin
        stateNext  = INT_PRI;
        streakNext = '0;
      end
    endcase

    // Single floats are indexed by writeReg in the register file.
    if (issueFp) begin
      writeRegfN   = issueEnt.dest;
      writeData1fN = issueEnt.data1;
      if (issueEnt.dbl) begin
        writeData2fN = issueEnt.data2;
        regDWritefN  = 1'b1;
      end else begin
        writeRegN  = issueEnt.dest;
        regWritefN = 1'b1;
      end
    end

    fifoPush = fpAcc & ~fpBad & ~fpBypass;
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Randomized bench for rf_writeback_arbiter against a queue-based behavioural model.
module tb_rf_writeback_arbiter;

  localparam int unsigned FP_DEPTH   = 4;
  localparam int unsigned STREAK_MAX = 3;
  localparam int unsigned CNT_W      = $clog2(FP_DEPTH) + 1;
  localparam int          N_CYCLES   = 3200;

  logic             clk = 1'b0;
  logic             rst;
  logic             int_valid, int_ready, fp_valid, fp_ready, fp_dbl;
  logic [4:0]       int_reg, fp_reg, writeReg, writeRegf;
  logic [31:0]      int_data, fp_data1, fp_data2, writeData, writeData1f, writeData2f;
  logic             regWrite, regWritef, regDWritef, fp_err;
  logic [CNT_W-1:0] fp_count;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .FP_DEPTH   (FP_DEPTH),
    .STREAK_MAX (STREAK_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .int_valid   (int_valid),
    .int_ready   (int_ready),
    .int_reg     (int_reg),
    .int_data    (int_data),
    .fp_valid    (fp_valid),
    .fp_ready    (fp_ready),
    .fp_dbl      (fp_dbl),
    .fp_reg      (fp_reg),
    .fp_data1    (fp_data1),
    .fp_data2    (fp_data2),
    .writeReg    (writeReg),
    .writeData   (writeData),
    .regWrite    (regWrite),
    .writeRegf   (writeRegf),
    .writeData1f (writeData1f),
    .writeData2f (writeData2f),
    .regWritef   (regWritef),
    .regDWritef  (regDWritef),
    .fp_err      (fp_err),
    .fp_count    (fp_count)
  );

  typedef struct {
    bit        dbl;
    bit [4:0]  rg;
    bit [31:0] d1;
    bit [31:0] d2;
  } fpReq_t;

  // Model state: pending floats in arrival order, int-streak count, forced-float flag.
  fpReq_t    fq[$];
  int        streak;
  bit        forced;
  bit        eRegWrite, eRegWritef, eRegDWritef, eErr;
  bit [4:0]  eWriteReg, eWriteRegf;
  bit [31:0] eWriteData, eD1, eD2;
  bit        intAccLast, fpAccLast;

  int total = 0;
  int bad   = 0;
  int forceSeen = 0, fullSeen = 0, errSeen = 0, dblSeen = 0, sglSeen = 0, bypassSeen = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    fpReq_t req, ent;
    bit intAcc, fpAcc, badReq, wasEmpty, issueF, bypassed;
    eRegWrite   = 1'b0;
    eRegWritef  = 1'b0;
    eRegDWritef = 1'b0;
    eErr        = 1'b0;
    if (rst) begin
      fq.delete();
      streak     = 0;
      forced     = 1'b0;
      intAccLast = 1'b0;
      fpAccLast  = 1'b0;
      return;
    end
    req      = '{dbl: fp_dbl, rg: fp_reg, d1: fp_data1, d2: fp_data2};
    ent      = req;
    intAcc   = int_valid && !forced;
    fpAcc    = fp_valid && (fq.size() < int'(FP_DEPTH));
    badReq   = (fp_reg == 5'd0) || (fp_dbl && fp_reg == 5'd31);
    wasEmpty = (fq.size() == 0);
    issueF   = 1'b0;
    bypassed = 1'b0;
    eErr     = fpAcc && badReq;
    if (eErr) errSeen++;

    if (forced) begin
      if (!wasEmpty) begin ent = fq.pop_front(); issueF = 1'b1; end
      forced = 1'b0;
      streak = 0;
    end else if (intAcc) begin
      eWriteReg  = int_reg;
      eWriteData = int_data;
      eRegWrite  = (int_reg != 5'd0);
      if (wasEmpty) streak = 0;
      else begin
        streak++;
        if (streak == int'(STREAK_MAX)) begin forced = 1'b1; forceSeen++; end
      end
    end else if (!wasEmpty) begin
      ent    = fq.pop_front();
      issueF = 1'b1;
      streak = 0;
    end else begin
      streak = 0;
`ifdef RF_WB_BYPASS_EN
      if (fpAcc && !badReq) begin ent = req; issueF = 1'b1; bypassed = 1'b1; bypassSeen++; end
`endif
    end

    if (issueF) begin
      eWriteRegf = ent.rg;
      eD1        = ent.d1;
      eD2        = ent.d2;
      if (ent.dbl) begin eRegDWritef = 1'b1; dblSeen++; end
      else begin eRegWritef = 1'b1; sglSeen++; end
    end
    if (fpAcc && !badReq && !bypassed) fq.push_back(req);
    intAccLast = intAcc;
    fpAccLast  = fpAcc;
  endtask

  task automatic checkOutputs();
    checkEq("regWrite",   regWrite,   eRegWrite);
    checkEq("regWritef",  regWritef,  eRegWritef);
    checkEq("regDWritef", regDWritef, eRegDWritef);
    checkEq("fp_err",     fp_err,     eErr);
    checkEq("fp_count",   fp_count,   32'(fq.size()));
    checkEq("int_ready",  int_ready,  !forced);
    checkEq("fp_ready",   fp_ready,   fq.size() < int'(FP_DEPTH));
    if (eRegWrite) begin
      checkEq("writeReg",  writeReg,  eWriteReg);
      checkEq("writeData", writeData, eWriteData);
    end
    if (eRegWritef || eRegDWritef) begin
      checkEq("writeRegf",   writeRegf,   eWriteRegf);
      checkEq("writeData1f", writeData1f, eD1);
    end
    if (eRegDWritef) checkEq("writeData2f", writeData2f, eD2);
    if (eRegWritef)  checkEq("writeReg_sgl", writeReg, eWriteRegf);
    if (fq.size() == int'(FP_DEPTH)) fullSeen++;
  endtask

  task automatic newInt(input int pct);
    int_valid = ($urandom_range(99) < 32'(pct));
    int_reg   = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom);
    int_data  = $urandom;
  endtask

  // Register choice biased toward the illegal corners r0 and r31.
  task automatic newFp(input int pct);
    int unsigned r;
    r         = $urandom_range(15);
    fp_valid  = ($urandom_range(99) < 32'(pct));
    fp_dbl    = 1'($urandom_range(1));
    fp_reg    = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom);
    fp_data1  = $urandom;
    fp_data2  = $urandom;
  endtask

  initial begin
    int intPct, fpPct;
    rst = 1'b1;
    int_valid = 1'b0; int_reg = '0; int_data = '0;
    fp_valid = 1'b0; fp_dbl = 1'b0; fp_reg = '0; fp_data1 = '0; fp_data2 = '0;
    modelStep();
    @(posedge clk);
    rst = 1'b0;
    newInt(0);
    newFp(0);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      checkOutputs();
      if      (cyc < 800)  begin intPct = 95;  fpPct = 60; end
      else if (cyc < 1600) begin intPct = 30;  fpPct = 30; end
      else if (cyc < 2400) begin intPct = 0;   fpPct = 50; end
      else                 begin intPct = 100; fpPct = 80; end
      rst = (cyc > 20) && ($urandom_range(149) == 0);
      // A source holds its request until it is accepted.
      if (!(int_valid && !intAccLast)) newInt(intPct);
      if (!(fp_valid && !fpAccLast))   newFp(fpPct);
      modelStep();
    end
    @(negedge clk);
    checkOutputs();

    checkEq("cov_forced_float", 32'(forceSeen > 0), 32'd1);
    checkEq("cov_fifo_full",    32'(fullSeen > 0),  32'd1);
    checkEq("cov_illegal",      32'(errSeen > 0),   32'd1);
    checkEq("cov_double",       32'(dblSeen > 0),   32'd1);
    checkEq("cov_single",       32'(sglSeen > 0),   32'd1);
`ifdef RF_WB_BYPASS_EN
    checkEq("cov_bypass",       32'(bypassSeen > 0), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side initiator for the 32x32 integer/float register file.
- Merges the integer writeback stream and the float writeback stream (single and double-word) into the register file write port.
- The register file drops a float write when an integer write occurs in the same cycle, so this block guarantees at most one write class per cycle.
- Buffers float writes in a small FIFO, with an anti-starvation scheme. Sits between the WB stage and the register file.

Parameters:
- FP_DEPTH, 4, float write FIFO entries (power of 2, ≥2).
- STREAK_MAX, 3, consecutive integer issues allowed while the float FIFO is non-empty before one float issue is forced.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- int_valid  in  1  integer writeback request.
- int_ready  out  1  integer request accepted this cycle when int_valid & int_ready.
- int_reg  in  5  integer destination.
- int_data  in  32  integer write data.
- fp_valid  in  1  float writeback request.
- fp_ready  out  1  float request accepted this cycle when fp_valid & fp_ready.
- fp_dbl  in  1  1 = double write (fp_reg, fp_reg+1).
- fp_reg  in  5  float destination.
- fp_data1  in  32  low/single word.
- fp_data2  in  32  high word (double only).
- writeReg  out  5  to register file.
- writeData  out  32  to register file.
- regWrite  out  1  to register file.
- writeRegf  out  5  to register file.
- writeData1f  out  32  to register file.
- writeData2f  out  32  to register file.
- regWritef  out  1  to register file.
- regDWritef  out  1  to register file.
- fp_err  out  1  one-cycle pulse: illegal float write dropped.
- fp_count  out  $clog2(FP_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, streak counter 0, FSM = INT_PRI. A write in flight at reset is discarded; outputs are 0 in the cycle after rst.
- Register-file outputs are registered. Issue decision at posedge N drives the outputs for cycle N→N+1.
- fp_ready = FIFO not full (registered occupancy); int_ready = (FSM != FP_FORCE).
- Integer path: accept at edge N → regWrite=1, writeReg/writeData valid in the following cycle (latency 1, no buffering).
- Float path: enqueue at edge N; earliest issue at edge N+1 (latency 2).
- FSM states:
  - INT_PRI: an accepted int request issues. Otherwise the FIFO head issues if non-empty. The streak counter increments on each int issue while the FIFO is non-empty, and clears on any float issue or when the FIFO is empty. When the counter reaches STREAK_MAX, go to FP_FORCE.
  - FP_FORCE: int_ready=0; the FIFO head issues; counter clears; return to INT_PRI next cycle.
- Float issue encoding:
  - Double: regDWritef=1, regWritef=0, writeRegf=fp_reg, writeData1f/writeData2f = data.
  - Single: regWritef=1, regDWritef=0, writeRegf=fp_reg, writeData1f=data. writeReg is also driven with fp_reg, because the register file indexes single float writes by writeReg; regWrite stays 0.
- Integer issue drives regWritef=regDWritef=0.
- Illegal float writes are accepted, never enqueued, and pulse fp_err the next cycle: double with fp_reg=0 or 31, or single with fp_reg=0.
- Integer write to r0: accepted, regWrite held 0.
- Simultaneous enqueue and dequeue when full: not allowed. fp_ready is low when full regardless of the dequeue.
- Pointers wrap modulo FP_DEPTH.
- Idle cycles: all write strobes 0. Data/index outputs hold their last values.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined: when the FIFO is empty, the FSM is INT_PRI and no int request is accepted this cycle, an accepted legal float request issues directly at edge N (latency 1) without being enqueued.
- Undefined: every float write passes through the FIFO (latency ≥2).

Decomposition:
- Shared package rf_wb_pkg holds:
  - the float-entry struct/field widths (dbl, reg[4:0], data1, data2 = 70 bits);
  - constants REG_ZERO=5'd0 and REG_LAST=5'd31;
  - FSM state encodings INT_PRI/FP_FORCE.
- One sub-module: rf_wb_fifo (synchronous FIFO, width 70, depth FP_DEPTH, full/empty/count).

Test Plan:
- Reset mid-traffic: FIFO holding 2 entries, assert rst → next cycle all strobes 0, fp_count=0, int_ready=1, fp_ready=1.
- Int r5=0xDEADBEEF at edge 1 → regWrite=1, writeReg=5, writeData=0xDEADBEEF in cycle 1-2 only; regWritef=regDWritef=0.
- Float double f4 = (0x11111111, 0x22222222) with no int traffic → after 2 edges regDWritef=1, writeRegf=4, data words correct. Single f7 → regWritef=1, writeRegf=7, writeReg=7, regWrite=0.
- Starvation: queue 1 float, hold int_valid every cycle with STREAK_MAX=3 → 3 int issues, then int_ready=0 for one cycle and the float issues, then ints resume.
- FIFO full: 4 floats enqueued during continuous forced int priority → fp_ready=0 and fp_count=4; a fifth request is held until the first float dequeues. FIFO order is preserved across pointer wrap (8+ entries total).
- Illegal writes: double f31, double f0, single f0 → each accepted, fp_err pulses once, no strobe ever asserted. With RF_WB_BYPASS_EN, a legal single f9 into an empty FIFO issues after 1 edge.
